// File: rtl/ladybird_timer_if.sv
// ladybird_bus_interface: crossbar-to-peripheral bus.
//   req    : access request from the crossbar
//   addr   : byte address
//   wstrb  : byte write strobes (all zero means a load)
//   wdata  : store data
//   gnt    : request accepted this cycle
//   rdgnt  : load data valid (single-cycle pulse)
//   rdata  : load data
// The primary modport is the crossbar side; the secondary modport is the peripheral side.
interface ladybird_bus_interface;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        gnt;
  logic        rdgnt;
  logic [31:0] rdata;

  modport primary (
    output req, addr, wstrb, wdata,
    input  gnt, rdgnt, rdata
  );

  modport secondary (
    input  req, addr, wstrb, wdata,
    output gnt, rdgnt, rdata
  );
endinterface

// File: rtl/ladybird_timer.sv
// ladybird_timer: machine timer (mtime/mtimecmp), software interrupt bit and
// prescaled tick generator behind a ladybird bus secondary port.
// Ports:
//   clk       : clock, all state on the rising edge
//   nrst      : synchronous active-low reset
//   bus       : ladybird_bus_interface.secondary, one crossbar peripheral port
//   timer_irq : machine timer interrupt, registered (mtime >= mtimecmp)
//   soft_irq  : machine software interrupt, equal to msip[0]
// Register map by addr[4:2]: 0 mtime lo, 1 mtime hi, 2 mtimecmp lo,
// 3 mtimecmp hi, 4 msip, 5 ctrl {prescale[15:8], enable[0]}, 6-7 read 0.
module ladybird_timer #(
  parameter logic [63:0] MTIME_RESET    = 64'h0,
  parameter logic [7:0]  PRESCALE_RESET = 8'd0
) (
  input  logic                          clk,
  input  logic                          nrst,
  ladybird_bus_interface.secondary      bus,
  output logic                          timer_irq,
  output logic                          soft_irq
);

  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic        msip_r;
  logic        enable_r;
  logic [7:0]  prescale_r;
  logic [7:0]  pcnt_r;
  logic        rd_pending_r;
  logic [31:0] rdata_r;
  logic        timer_irq_r;

  logic [2:0]  sel_s;
  logic        store_s;
  logic        load_s;
  logic        tick_s;
  logic [31:0] rd_val_s;
  logic [63:0] mtime_nxt_s;
  logic [63:0] mtimecmp_nxt_s;
  logic [7:0]  pcnt_nxt_s;
  logic        unused_addr_s;

  // Byte-lane merge: lane k takes new data only where its strobe is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_val[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_val[8*k +: 8];
      end
    end
    return res;
  endfunction

  assign sel_s         = bus.addr[4:2];
  assign unused_addr_s = ^{bus.addr[31:5], bus.addr[1:0]};
  // Only one load may be outstanding; stores are never held off otherwise.
  assign store_s       = bus.req & ~rd_pending_r & (bus.wstrb != 4'b0000);
  assign load_s        = bus.req & ~rd_pending_r & (bus.wstrb == 4'b0000);
  assign tick_s        = enable_r & (pcnt_r == prescale_r);

  // Read mux over the current (pre-update) register values.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    case (sel_s)
      3'd0:    rd_val_s = mtime_r[31:0];
      3'd1:    rd_val_s = mtime_r[63:32];
      3'd2:    rd_val_s = mtimecmp_r[31:0];
      3'd3:    rd_val_s = mtimecmp_r[63:32];
      3'd4:    rd_val_s = {31'd0, msip_r};
      3'd5:    rd_val_s = {16'd0, prescale_r, 7'd0, enable_r};
      default: rd_val_s = 32'h0000_0000;
    endcase
  end

  // Next-state for mtime, mtimecmp and the prescale counter. A software store
  // to either mtime half wins over a tick in the same cycle and the tick is lost.
  always_comb begin
    mtime_nxt_s    = mtime_r;
    mtimecmp_nxt_s = mtimecmp_r;
    pcnt_nxt_s     = pcnt_r;

    if (store_s && (sel_s == 3'd0)) begin
      mtime_nxt_s[31:0] = merge_bytes(mtime_r[31:0], bus.wdata, bus.wstrb);
    end else if (store_s && (sel_s == 3'd1)) begin
      mtime_nxt_s[63:32] = merge_bytes(mtime_r[63:32], bus.wdata, bus.wstrb);
    end else if (tick_s) begin
      mtime_nxt_s = mtime_r + 64'd1;
    end else begin
      mtime_nxt_s = mtime_r;
    end

    if (store_s && (sel_s == 3'd2)) begin
      mtimecmp_nxt_s[31:0] = merge_bytes(mtimecmp_r[31:0], bus.wdata, bus.wstrb);
    end else if (store_s && (sel_s == 3'd3)) begin
      mtimecmp_nxt_s[63:32] = merge_bytes(mtimecmp_r[63:32], bus.wdata, bus.wstrb);
    end else begin
      mtimecmp_nxt_s = mtimecmp_r;
    end

    if (store_s && (sel_s == 3'd5)) begin
      pcnt_nxt_s = 8'd0;
    end else if (tick_s) begin
      pcnt_nxt_s = 8'd0;
    end else if (enable_r) begin
      pcnt_nxt_s = pcnt_r + 8'd1;
    end else begin
      pcnt_nxt_s = pcnt_r;
    end
  end

  // State registers; the irq compare uses the post-update values.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      mtime_r      <= MTIME_RESET;
      mtimecmp_r   <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_r       <= 1'b0;
      enable_r     <= 1'b1;
      prescale_r   <= PRESCALE_RESET;
      pcnt_r       <= 8'd0;
      rd_pending_r <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      timer_irq_r  <= 1'b0;
    end else begin
      mtime_r      <= mtime_nxt_s;
      mtimecmp_r   <= mtimecmp_nxt_s;
      pcnt_r       <= pcnt_nxt_s;
      rd_pending_r <= load_s;
      timer_irq_r  <= (mtime_nxt_s >= mtimecmp_nxt_s);
      if (load_s) begin
        rdata_r <= rd_val_s;
      end
      if (store_s && (sel_s == 3'd4) && bus.wstrb[0]) begin
        msip_r <= bus.wdata[0];
      end
      if (store_s && (sel_s == 3'd5) && bus.wstrb[0]) begin
        enable_r <= bus.wdata[0];
      end
      if (store_s && (sel_s == 3'd5) && bus.wstrb[1]) begin
        prescale_r <= bus.wdata[15:8];
      end
    end
  end

  // rd_pending doubles as the rdgnt pulse: high exactly the cycle after acceptance.
  assign bus.gnt   = ~rd_pending_r;
  assign bus.rdgnt = rd_pending_r;
  assign bus.rdata = rdata_r;
  assign timer_irq = timer_irq_r;
  assign soft_irq  = msip_r;

endmodule
